stopwatch: RTL and testbench
============================

# stopwatch

Elapsed-time measurement peripheral for the nano6502 system bus, the counterpart to the countdown timer: the CPU starts it, it counts up in milliseconds, and the CPU reads back how long something took. It decodes a 3-bit register window selected by its chip-select and is polled by software. It uses the same bus port conventions as the other I/O cores.

## Interface
- CLK_FRE, 25_175_000: system clock frequency in Hz.
- MS_DIV, CLK_FRE/1000: clock cycles per millisecond tick. Must be at least 2.
- COUNT_W, 24: width of the millisecond counter. Legal range is 8..24.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- R_W_n  in  1  bus direction: 1 = read, 0 = write.
- reg_addr_i  in  3  register select.
- data_i  in  8  write data.
- stopwatch_cs  in  1  chip select.
- data_o  out  8  read data. Combinational from reg_addr_i.

## Operation
Register map:
- 0, status (read-only): bit0 = running, bit1 = overflow (sticky), bits 7:2 = 0.
- 1, control (write-only; reads return 0):
  - bit0 start
  - bit1 stop
  - bit2 clear
  - bit3 latch
- 2, 3, 4: snapshot bytes LSB, mid, MSB. Bits at or above COUNT_W read as 0.
- 5..7: read 0. Writes to these addresses are ignored.

Write action:
- A write occurs on every clock edge where stopwatch_cs=1 and R_W_n=0.
- All control actions are idempotent, so a write held for several cycles produces the same result as a one-cycle write.

State machine has two states, IDLE and RUNNING:
- IDLE to RUNNING: start=1 and stop=0.
- RUNNING to IDLE: stop=1. Stopping also copies the live count into the snapshot.
- Start while RUNNING does nothing; it does not reset the count.

Control bit priority within one write:
- clear is applied first. It zeroes the live count, the prescaler, and the overflow flag. It does not change the state or the snapshot.
- stop beats start.
- latch copies the post-clear live count into the snapshot.

Prescaler:
- Counts 0..MS_DIV-1, and only in RUNNING.
- On wrap it asserts a one-cycle tick, and the live count increments.
- The prescaler holds its value while IDLE, so a stop/start pair preserves the partial millisecond.

Overflow:
- The live count wraps from 2^COUNT_W-1 to 0 and sets the overflow flag.
- The stopwatch keeps running.
- The flag stays set until clear or reset.

Snapshot:
- Changes only on latch, stop, or reset.
- Reads never change it, so multi-byte reads are coherent.

## Timing
Reset values (rst_i=1, async) apply to everything at once:
- State = IDLE, prescaler = 0, live count = 0, snapshot = 0, overflow = 0.
- data_o therefore reads 0x00 at every address.

Latencies:
- A write sampled at edge N takes effect at edge N. New status and snapshot values are visible on data_o in cycle N+1.
- The first tick after start at edge N occurs at edge N+MS_DIV, provided the prescaler was 0.
- A latch at edge N captures the live count as it is before any tick occurring at that same edge.
- Tick and clear at the same edge: clear wins and the count becomes 0.
- Tick and stop at the same edge: the tick is counted, and the snapshot holds the incremented value.

Reset behaviour:
- Deasserting reset mid-run leaves the block in IDLE.
- Software must restart it.

## Structure
Shared package nano6502_io_pkg contains:
- Register address constants: REG_STATUS, REG_CTRL, REG_SNAP0..2.
- Status bit indices: STAT_RUN, STAT_OVF.
- Control bit indices: CTL_START, CTL_STOP, CTL_CLEAR, CTL_LATCH.
- The two-state enum.

One sub-module, stopwatch_tick:
- Parameterised by MS_DIV.
- Inputs: enable, clear. Output: one-cycle tick.
- It is reused later by the countdown timer.

## Test plan
All scenarios use CLK_FRE=10_000, so MS_DIV=10.
1. Reset, no writes: addresses 0..7 all read 0x00. Then assert rst_i mid-run: status reads 0x00 in the same cycle.
2. Write 0x01 to reg 1, wait 105 cycles, write 0x08: snapshot reads 0x0A, 0x00, 0x00 and status reads 0x01.
3. Start, write 0x02 after 255 cycles: snapshot reads 25 (0x19) and status reads 0x00. Wait 100 more cycles and write 0x08: snapshot still reads 0x19. Write 0x01, wait 50 cycles, write 0x0A: snapshot reads 30, which confirms the partial millisecond was preserved.
4. While running at count 5, write 0x07: status reads 0x00 and a following latch (0x08) gives snapshot 0.
5. With COUNT_W=8, run 2565 cycles, then latch: status reads 0x03 and snapshot reads 0x00. Write 0x04 (clear): status reads 0x01.
6. Hold a 0x01 write for 3 cycles: the result is identical to a single-cycle start. Writes to reg 5 are ignored and reads of reg 5 return 0x00.

Source files
------------

// File: rtl/nano6502_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nano6502_io_pkg
// Description : Shared register map, bit indices and state type for the
//               nano6502 I/O cores (stopwatch, countdown timer).
// Revision    : 1.0 - initial release
// ============================================================================
package nano6502_io_pkg;

  // Register window offsets
  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_SNAP0  = 3'd2;
  localparam logic [2:0] REG_SNAP1  = 3'd3;
  localparam logic [2:0] REG_SNAP2  = 3'd4;

  // Status register bit positions
  localparam int STAT_RUN = 0;
  localparam int STAT_OVF = 1;

  // Control register bit positions
  localparam int CTL_START = 0;
  localparam int CTL_STOP  = 1;
  localparam int CTL_CLEAR = 2;
  localparam int CTL_LATCH = 3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } sw_state_e;

endpackage
`default_nettype wire

// File: rtl/stopwatch_tick.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_tick
// Description : Millisecond prescaler. Counts 0..MS_DIV-1 while enabled and
//               flags the wrap cycle with a one-cycle tick. Holds its value
//               while disabled so a pause keeps the partial period.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_tick #(
  parameter int MS_DIV = 25_175
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int               CNT_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MS_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick is combinational so the consumer acts on the same edge as the wrap
  assign tick_o = en_i && (cnt_q == CNT_MAX);

  // Next prescaler value: clear dominates, otherwise count and wrap when enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch
// Description : Bus-polled elapsed-time peripheral. Counts milliseconds while
//               running, with a software-visible snapshot register that only
//               changes on latch/stop so multi-byte reads stay coherent.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch
  import nano6502_io_pkg::*;
#(
  parameter int CLK_FRE = 25_175_000,
  parameter int MS_DIV  = CLK_FRE / 1000,
  parameter int COUNT_W = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       R_W_n,
  input  logic [2:0] reg_addr_i,
  input  logic [7:0] data_i,
  input  logic       stopwatch_cs,
  output logic [7:0] data_o
);

  sw_state_e          state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] snap_q,  snap_d;
  logic               ovf_q,   ovf_d;

  logic        w_ctl_wr;
  logic        w_start, w_stop, w_clear, w_latch;
  logic        w_running;
  logic        w_tick;
  logic [23:0] w_snap_ext;
  logic        w_unused;

  // Control strobes; the upper data bits carry no function
  assign w_ctl_wr  = stopwatch_cs && !R_W_n && (reg_addr_i == REG_CTRL);
  assign w_start   = w_ctl_wr && data_i[CTL_START];
  assign w_stop    = w_ctl_wr && data_i[CTL_STOP];
  assign w_clear   = w_ctl_wr && data_i[CTL_CLEAR];
  assign w_latch   = w_ctl_wr && data_i[CTL_LATCH];
  assign w_running = (state_q == ST_RUNNING);
  assign w_unused  = &{1'b0, data_i[7:4]};

  stopwatch_tick #(
    .MS_DIV (MS_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (w_running),
    .clr_i  (w_clear),
    .tick_o (w_tick)
  );

  // Next state plus count/overflow/snapshot updates with clear > stop > start
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    snap_d  = snap_q;

    case (state_q)
      ST_IDLE:    if (w_start && !w_stop) state_d = ST_RUNNING;
      ST_RUNNING: if (w_stop)             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase

    if (w_clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (w_tick) begin
      count_d = count_q + COUNT_W'(1);
      if (count_q == '1) ovf_d = 1'b1;
    end

    // Latch sees the count before any same-edge tick; stop sees it after
    if (w_latch) snap_d = w_clear ? '0 : count_q;
    if (w_stop && w_running) snap_d = count_d;
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
    end
  end

  generate
    if (COUNT_W < 24) begin : g_snap_pad
      assign w_snap_ext = {{(24 - COUNT_W){1'b0}}, snap_q};
    end else begin : g_snap_full
      assign w_snap_ext = snap_q[23:0];
    end
  endgenerate

  // Read mux; control and unmapped addresses read as zero
  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      REG_STATUS: begin
        data_o[STAT_RUN] = w_running;
        data_o[STAT_OVF] = ovf_q;
      end
      REG_SNAP0: data_o = w_snap_ext[7:0];
      REG_SNAP1: data_o = w_snap_ext[15:8];
      REG_SNAP2: data_o = w_snap_ext[23:16];
      default:   data_o = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch
// Description : Directed scoreboard bench for stopwatch at MS_DIV = 10, with a
//               second 8-bit-counter instance for the overflow scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch;

  localparam logic [2:0] A_STAT = 3'd0;
  localparam logic [2:0] A_CTRL = 3'd1;
  localparam logic [2:0] A_SN0  = 3'd2;
  localparam logic [2:0] A_SN1  = 3'd3;
  localparam logic [2:0] A_SN2  = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rw_n = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'h00;
  logic       cs24 = 1'b0;
  logic       cs8 = 1'b0;
  logic [7:0] do24;
  logic [7:0] do8;
  logic       rd_stb = 1'b0;
  logic       rd_sel = 1'b0;
  logic [7:0] got;

  logic [7:0] exp_q[$];
  string      name_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  stopwatch #(.CLK_FRE(10_000), .COUNT_W(24)) dut24 (
    .clk_i        (clk),
    .rst_i        (rst),
    .R_W_n        (rw_n),
    .reg_addr_i   (addr),
    .data_i       (wdata),
    .stopwatch_cs (cs24),
    .data_o       (do24)
  );

  stopwatch #(.CLK_FRE(10_000), .COUNT_W(8)) dut8 (
    .clk_i        (clk),
    .rst_i        (rst),
    .R_W_n        (rw_n),
    .reg_addr_i   (addr),
    .data_i       (wdata),
    .stopwatch_cs (cs8),
    .data_o       (do8)
  );

  assign got = rd_sel ? do8 : do24;

  // Monitor: every read cycle pops one expected byte and compares it
  always @(negedge clk) begin
    if (rd_stb) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got 0x%02h with nothing expected", got);
      end else begin
        logic [7:0] e;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", nm, got, e);
        end
      end
    end
  end

  task automatic sel_cs(input bit sel);
    if (sel) cs8 = 1'b1;
    else     cs24 = 1'b1;
  endtask

  task automatic wr(input bit sel, input logic [2:0] a, input logic [7:0] d, input int hold = 1);
    addr = a; wdata = d; rw_n = 1'b0;
    sel_cs(sel);
    repeat (hold) @(posedge clk);
    #1;
    cs24 = 1'b0; cs8 = 1'b0; rw_n = 1'b1;
  endtask

  task automatic rd(input bit sel, input logic [2:0] a, input logic [7:0] e, input string nm);
    addr = a; rw_n = 1'b1; rd_sel = sel;
    sel_cs(sel);
    exp_q.push_back(e);
    name_q.push_back(nm);
    rd_stb = 1'b1;
    @(posedge clk);
    #1;
    rd_stb = 1'b0; cs24 = 1'b0; cs8 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(2);
    rst = 1'b0;
    idle(1);

    // 1: reset values, then asynchronous reset mid-run
    for (int a = 0; a < 8; a++) rd(1'b0, 3'(a), 8'h00, "t1_reset_read");
    rd(1'b1, A_STAT, 8'h00, "t1_reset_status_w8");
    wr(1'b0, A_CTRL, 8'h01);
    idle(20);
    rd(1'b0, A_STAT, 8'h01, "t1_running");
    rst = 1'b1;
    rd(1'b0, A_STAT, 8'h00, "t1_status_during_reset");
    rst = 1'b0;
    idle(15);
    rd(1'b0, A_STAT, 8'h00, "t1_idle_after_reset");
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h00, "t1_count_frozen");

    // 2: start, 105 idle cycles, latch -> 10 ms
    do_reset();
    wr(1'b0, A_CTRL, 8'h01);
    idle(105);
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h0A, "t2_snap0");
    rd(1'b0, A_SN1, 8'h00, "t2_snap1");
    rd(1'b0, A_SN2, 8'h00, "t2_snap2");
    rd(1'b0, A_STAT, 8'h01, "t2_status");
    rd(1'b0, A_CTRL, 8'h00, "t2_ctrl_reads_zero");

    // First tick lands MS_DIV edges after start; latch on that edge sees 0
    do_reset();
    wr(1'b0, A_CTRL, 8'h01);
    idle(9);
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h00, "lat_latch_on_tick_edge");
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h01, "lat_latch_after_tick");

    // Stop on the tick edge counts the tick
    do_reset();
    wr(1'b0, A_CTRL, 8'h01);
    idle(9);
    wr(1'b0, A_CTRL, 8'h02);
    rd(1'b0, A_SN0, 8'h01, "stop_on_tick_snap");
    rd(1'b0, A_STAT, 8'h00, "stop_on_tick_status");

    // 3: stop at 255 cycles, snapshot stable, resume keeps partial ms
    do_reset();
    wr(1'b0, A_CTRL, 8'h01);
    idle(254);
    wr(1'b0, A_CTRL, 8'h02);
    rd(1'b0, A_SN0, 8'h19, "t3_stop_snap");
    rd(1'b0, A_STAT, 8'h00, "t3_stop_status");
    idle(100);
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h19, "t3_idle_latch");
    wr(1'b0, A_CTRL, 8'h01);
    idle(5);
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h1A, "t3_partial_ms_kept");
    idle(43);
    wr(1'b0, A_CTRL, 8'h0A);
    rd(1'b0, A_SN0, 8'h1E, "t3_resume_snap");
    rd(1'b0, A_STAT, 8'h00, "t3_resume_status");

    // 4: clear+stop+start while running at 5 ms
    do_reset();
    wr(1'b0, A_CTRL, 8'h01);
    idle(53);
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h05, "t4_count5");
    wr(1'b0, A_CTRL, 8'h07);
    rd(1'b0, A_STAT, 8'h00, "t4_status");
    rd(1'b0, A_SN0, 8'h00, "t4_stop_snap_after_clear");
    idle(20);
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h00, "t4_latch");
    rd(1'b0, A_STAT, 8'h00, "t4_still_idle");

    // 5: 8-bit counter wrap and sticky overflow
    do_reset();
    wr(1'b1, A_CTRL, 8'h01);
    idle(2554);
    wr(1'b1, A_CTRL, 8'h08);
    rd(1'b1, A_SN0, 8'hFF, "t5_pre_wrap_snap");
    rd(1'b1, A_STAT, 8'h01, "t5_pre_wrap_status");
    idle(7);
    wr(1'b1, A_CTRL, 8'h08);
    rd(1'b1, A_STAT, 8'h03, "t5_ovf_status");
    rd(1'b1, A_SN0, 8'h00, "t5_wrap_snap0");
    rd(1'b1, A_SN1, 8'h00, "t5_wrap_snap1");
    rd(1'b1, A_SN2, 8'h00, "t5_wrap_snap2");
    wr(1'b1, A_CTRL, 8'h04);
    rd(1'b1, A_STAT, 8'h01, "t5_clear_status");

    // 6: held start behaves like one-cycle start; reg 5 is inert
    do_reset();
    wr(1'b0, A_CTRL, 8'h01, 3);
    idle(7);
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h00, "t6_held_latch_tick_edge");
    wr(1'b0, A_CTRL, 8'h08);
    rd(1'b0, A_SN0, 8'h01, "t6_held_latch_after_tick");
    wr(1'b0, 3'd5, 8'h0E);
    rd(1'b0, A_STAT, 8'h01, "t6_reg5_write_status");
    rd(1'b0, A_SN0, 8'h01, "t6_reg5_write_snap");
    rd(1'b0, 3'd5, 8'h00, "t6_reg5_read");
    rd(1'b0, 3'd7, 8'h00, "t6_reg7_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
